// File: rtl/clb_array_cfg.sv
// Serially configured array of LUT-based logic elements, each with a
// registered/combinational output select, INIT value and optional clock enable.
module clb_array_cfg #(
  parameter int LUT_K  = 4,
  parameter int NUM_LE = 2
) (
  input  logic                    K,
  input  logic                    RST,
  input  logic                    CFG_EN,
  input  logic                    CFG_DIN,
  output logic                    CFG_DONE,
  input  logic [NUM_LE*LUT_K-1:0] IN,
  input  logic [NUM_LE-1:0]       CE,
  input  logic [NUM_LE-1:0]       SR,
  output logic [NUM_LE-1:0]       X,
  output logic [NUM_LE-1:0]       Y
);

  localparam int LUT_N   = 2**LUT_K;
  localparam int FRAME_W = LUT_N + 3;
  localparam int CFG_W   = NUM_LE * FRAME_W;
  localparam int CNT_W   = $clog2(CFG_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_W);

  logic [CFG_W-1:0]  cfg_sr;
  logic [CNT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              cfg_done;
  logic [NUM_LE-1:0] f;
  logic [NUM_LE-1:0] ysel;
  logic [NUM_LE-1:0] init;
  logic [NUM_LE-1:0] ceuse;
  logic [NUM_LE-1:0] init_load;
  logic [NUM_LE-1:0] q;
  logic [NUM_LE-1:0] q_run;

  for (genvar i = 0; i < NUM_LE; i++) begin : g_le
    logic [LUT_N-1:0] lut;

    assign lut      = cfg_sr[i*FRAME_W +: LUT_N];
    assign f[i]     = lut[IN[i*LUT_K +: LUT_K]];
    assign ysel[i]  = cfg_sr[i*FRAME_W + LUT_N];
    assign init[i]  = cfg_sr[i*FRAME_W + LUT_N + 1];
    assign ceuse[i] = cfg_sr[i*FRAME_W + LUT_N + 2];
    // The bit one below INIT is what lands in the INIT slot on this shift.
    assign init_load[i] = cfg_sr[i*FRAME_W + LUT_N];
    assign q_run[i] = SR[i] ? init[i] :
                      (!ceuse[i] || CE[i]) ? f[i] : q[i];
  end

  // A shift while already complete restarts the count at bit 1.
  assign cnt_nxt = (bit_cnt == CNT_FULL) ? CNT_W'(1) : bit_cnt + 1'b1;

  always_ff @(posedge K) begin
    if (RST) begin
      cfg_sr   <= '0;
      bit_cnt  <= '0;
      cfg_done <= 1'b0;
      q        <= '0;
    end else if (CFG_EN) begin
      cfg_sr   <= {cfg_sr[CFG_W-2:0], CFG_DIN};
      bit_cnt  <= cnt_nxt;
      cfg_done <= (cnt_nxt == CNT_FULL);
      if (cnt_nxt == CNT_FULL) begin
        q <= init_load;
      end
    end else if (cfg_done) begin
      q <= q_run;
    end
  end

  assign CFG_DONE = cfg_done;
  assign X        = cfg_done ? f : '0;
  assign Y        = cfg_done ? ((ysel & f) | (~ysel & q)) : '0;

endmodule

// File: tb/tb_clb_array_cfg.sv
// Directed self-checking bench for clb_array_cfg with LUT_K=4, NUM_LE=2.
module tb_clb_array_cfg;

  logic       K;
  logic       RST;
  logic       CFG_EN;
  logic       CFG_DIN;
  logic       CFG_DONE;
  logic [7:0] IN;
  logic [1:0] CE;
  logic [1:0] SR;
  logic [1:0] X;
  logic [1:0] Y;

  int n_chk  = 0;
  int n_pass = 0;

  logic [37:0] cfg_a;
  logic [37:0] cfg_b;
  logic [7:0]  pats [6];

  clb_array_cfg #(.LUT_K(4), .NUM_LE(2)) dut (
    .K       (K),
    .RST     (RST),
    .CFG_EN  (CFG_EN),
    .CFG_DIN (CFG_DIN),
    .CFG_DONE(CFG_DONE),
    .IN      (IN),
    .CE      (CE),
    .SR      (SR),
    .X       (X),
    .Y       (Y)
  );

  initial K = 1'b0;
  always #5 K = ~K;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h, expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge K);
    #1;
  endtask

  // Shifts n bits of v, starting at bit hi and moving downward.
  task automatic shift_bits(input logic [37:0] v, input int hi, input int n);
    for (int j = 0; j < n; j++) begin
      CFG_EN  = 1'b1;
      CFG_DIN = v[hi-j];
      tick();
    end
    CFG_EN = 1'b0;
  endtask

  initial begin
    // LE1 frame {CEUSE, INIT, YSEL, LUT}, then LE0 frame; MSB is shifted first.
    cfg_a = {1'b0, 1'b0, 1'b1, 16'h6996, 1'b1, 1'b1, 1'b0, 16'h8000};
    cfg_b = {1'b0, 1'b0, 1'b1, 16'h00FF, 1'b0, 1'b0, 1'b1, 16'h0001};
    pats[0] = 8'h00; pats[1] = 8'h1F; pats[2] = 8'h3F;
    pats[3] = 8'hEF; pats[4] = 8'h8F; pats[5] = 8'h5A;

    // Reset with every input active
    RST = 1'b1; CFG_EN = 1'b1; CFG_DIN = 1'b1; IN = 8'hA5; CE = 2'b11; SR = 2'b11;
    tick();
    RST = 1'b0; CFG_EN = 1'b0; CFG_DIN = 1'b0; IN = 8'h00; CE = 2'b00; SR = 2'b00;
    check("rst_done", 16'(CFG_DONE), 16'h0);
    check("rst_x", 16'(X), 16'h0);
    check("rst_y", 16'(Y), 16'h0);
    IN = 8'hFF;
    repeat (3) tick();
    check("idle_done", 16'(CFG_DONE), 16'h0);
    check("idle_x", 16'(X), 16'h0);
    check("idle_y", 16'(Y), 16'h0);

    // Full load
    shift_bits(cfg_a, 37, 37);
    check("done_after_37", 16'(CFG_DONE), 16'h0);
    check("x_after_37", 16'(X), 16'h0);
    shift_bits(cfg_a, 0, 1);
    check("done_after_38", 16'(CFG_DONE), 16'h1);
    IN = 8'h00; #1;
    check("y0_init", 16'(Y[0]), 16'h1);
    IN = 8'b0111_1111; #1;
    check("x_func", 16'(X), 16'h3);
    check("y1_comb", 16'(Y[1]), 16'h1);

    // LE0 is a 4-input AND, LE1 is 4-input parity
    for (int p = 0; p < 6; p++) begin
      IN = pats[p]; #1;
      check($sformatf("x_pat%0d", p), 16'(X), 16'({^pats[p][7:4], &pats[p][3:0]}));
    end

    // Clock-enable gating on LE0
    IN = 8'h00; CE = 2'b00;
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("ce_hold%0d", c), 16'(Y[0]), 16'h1);
    end
    CE[0] = 1'b1;
    tick();
    check("ce_load", 16'(Y[0]), 16'h0);

    // SR overrides CE
    SR[0] = 1'b1;
    tick();
    check("sr_set", 16'(Y[0]), 16'h1);
    SR[0] = 1'b0;
    tick();
    check("sr_release", 16'(Y[0]), 16'h0);
    CE = 2'b00;

    // Interrupted load
    RST = 1'b1; tick(); RST = 1'b0;
    check("rst2_done", 16'(CFG_DONE), 16'h0);
    shift_bits(cfg_a, 37, 20);
    repeat (5) tick();
    check("pause_done", 16'(CFG_DONE), 16'h0);
    shift_bits(cfg_a, 17, 17);
    check("resume_37", 16'(CFG_DONE), 16'h0);
    shift_bits(cfg_a, 0, 1);
    check("resume_done", 16'(CFG_DONE), 16'h1);
    IN = 8'b0111_1111; #1;
    check("resume_x", 16'(X), 16'h3);

    // Reset mid-load discards progress
    RST = 1'b1; tick(); RST = 1'b0;
    shift_bits(cfg_a, 37, 30);
    RST = 1'b1; CFG_EN = 1'b1; CFG_DIN = 1'b1; tick();
    RST = 1'b0; CFG_EN = 1'b0;
    check("midrst_done", 16'(CFG_DONE), 16'h0);
    shift_bits(cfg_a, 37, 37);
    check("midrst_37", 16'(CFG_DONE), 16'h0);
    shift_bits(cfg_a, 0, 1);
    check("midrst_38", 16'(CFG_DONE), 16'h1);
    IN = 8'b0111_1111; #1;
    check("midrst_x", 16'(X), 16'h3);

    // Reload with new contents
    IN = 8'hFF;
    shift_bits(cfg_b, 37, 1);
    check("reload_done", 16'(CFG_DONE), 16'h0);
    check("reload_x", 16'(X), 16'h0);
    check("reload_y", 16'(Y), 16'h0);
    shift_bits(cfg_b, 36, 36);
    check("reload_37", 16'(CFG_DONE), 16'h0);
    shift_bits(cfg_b, 0, 1);
    check("reload_38", 16'(CFG_DONE), 16'h1);
    IN = 8'h00; #1;
    check("new_x_00", 16'(X), 16'h3);
    check("new_y_00", 16'(Y), 16'h3);
    IN = 8'h80; #1;
    check("new_x_80", 16'(X), 16'h1);
    IN = 8'h0F; #1;
    check("new_x_0f", 16'(X), 16'h2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/clb_array_cfg.md
CLB_ARRAY_CFG -- requirements
Module: clb_array_cfg

Interface
REQ-001 SHALL have parameter LUT_K, default 4: inputs per LUT; legal range 2..6.
REQ-002 SHALL have parameter NUM_LE, default 2: number of logic elements (LEs); legal range 1..8.
REQ-003 SHALL define derived FRAME_W = 2**LUT_K + 3 and CFG_W = NUM_LE*FRAME_W.
REQ-004 K  in  1  sole clock; all state updates on rising edge.
REQ-005 RST  in  1  reset, synchronous, active-high.
REQ-006 CFG_EN  in  1  configuration shift enable.
REQ-007 CFG_DIN  in  1  configuration serial data.
REQ-008 CFG_DONE  out  1  high when a complete configuration is loaded.
REQ-009 IN  in  NUM_LE*LUT_K  LUT inputs; LE i uses IN[i*LUT_K +: LUT_K], and the MSB of that slice is the MSB of the LUT index.
REQ-010 CE  in  NUM_LE  per-LE clock enable.
REQ-011 SR  in  NUM_LE  per-LE synchronous set/reset to the INIT value.
REQ-012 X  out  NUM_LE  per-LE combinational LUT output.
REQ-013 Y  out  NUM_LE  per-LE selectable output: registered or combinational.

Function
REQ-014 SHALL hold a CFG_W-bit shift register.
- LE i frame occupies bits [i*FRAME_W +: FRAME_W].
- Within a frame: [2**LUT_K-1:0] = LUT, next bit = YSEL, next = INIT, top bit = CEUSE.
REQ-015 SHALL shift each edge with CFG_EN=1: cfg <= {cfg[CFG_W-2:0], CFG_DIN}. The first bit shifted in ends at bit CFG_W-1.
REQ-016 SHALL keep a bit counter 0..CFG_W.
- Each CFG_EN=1 edge increments the counter; if the counter was CFG_W it becomes 1 instead.
- CFG_DONE = (counter == CFG_W), registered.
REQ-017 Deasserting CFG_EN mid-load SHALL hold the counter and shift register; load resumes on the next CFG_EN=1.
REQ-018 Asserting CFG_EN while CFG_DONE=1 SHALL start a new load: CFG_DONE drops the following cycle, and the shifted bit is counted as bit 1.
REQ-019 LE i combinational value F_i SHALL be LUT_i[IN slice i].
REQ-020 Outputs SHALL be X_i = CFG_DONE ? F_i : 0.
REQ-021 Outputs SHALL be Y_i = CFG_DONE ? (YSEL_i ? F_i : Q_i) : 0.
REQ-022 On the edge where the counter reaches CFG_W, each Q_i SHALL load INIT_i, from the newly completed frame.
REQ-023 While CFG_DONE=1 and CFG_EN=0, each Q_i SHALL update in this priority order:
- SR_i=1 -> Q_i <= INIT_i.
- else CEUSE_i=0 or CE_i=1 -> Q_i <= F_i.
- else hold.
REQ-024 While CFG_DONE=0, or while CFG_EN=1, Q SHALL hold, except as given in REQ-022.
REQ-025 The design SHALL contain no latches and no combinational loops; LUT output delay is not modelled.

Reset
REQ-026 On RST=1 at a rising K edge, the block SHALL clear the shift register, counter, CFG_DONE and all Q_i to 0. X and Y are 0 the same cycle after the edge.
REQ-027 RST SHALL take priority over CFG_EN, SR and CE. A load in progress is discarded and a full CFG_W-bit reload is required.

Verification (LUT_K=4, NUM_LE=2, FRAME_W=19, CFG_W=38)
REQ-028 Reset: drive RST for 1 cycle with all inputs toggling -> CFG_DONE=0, X=0, Y=0, and they stay 0 with CFG_EN=0.
REQ-029 Load and function: shift 38 bits.
- LE1 frame: CEUSE=0, INIT=0, YSEL=1, LUT=16'h6996.
- LE0 frame: CEUSE=1, INIT=1, YSEL=0, LUT=16'h8000.
- Required: CFG_DONE=1 after the 38th edge, not after the 37th; Y[0]=1 (INIT).
- Then IN=8'b0111_1111 -> X=2'b11, Y[1]=1.
REQ-030 CE gating: LE0 configured as above, IN[3:0]=4'b0000, CE[0]=0 for 3 edges -> Y[0] stays 1. Then CE[0]=1 for 1 edge -> Y[0]=0.
REQ-031 SR priority: SR[0]=1 and CE[0]=1 with F_0=0 -> Y[0]=1 after the edge. Then SR[0]=0 -> Y[0]=0 after the next edge.
REQ-032 Interrupted load and reset: shift 20 bits, hold CFG_EN=0 for 5 cycles, then shift 18 bits -> CFG_DONE=1. A second run asserts RST after 30 bits -> CFG_DONE stays 0 until 38 further bits are shifted.
REQ-033 Reload: with CFG_DONE=1, assert CFG_EN -> CFG_DONE=0 and X=0 the next cycle. After 38 bits the new LUT contents take effect.
